// File: rtl/decode_pkg.sv
// Types and pairing helpers shared by the instruction decoder and the decode queue.
package decode_pkg;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  reg_t;

  typedef enum logic [3:0] {
    ALU_NONE, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_t;

  typedef struct packed {
    alu_op_t     alu_op;
    reg_t        srca;
    reg_t        srcb;
    reg_t        dest;
    logic [15:0] imm;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        is_multdiv;
    logic        cp0write;
    logic        writes_hi;
    logic        writes_lo;
    logic        is_branch;
    logic        is_jump;
    logic        is_eret;
    logic        is_bp;
    logic        is_sys;
    logic        exception_ri;
    word_t       pcplus4;
  } decoded_instr_t;

  typedef struct packed {
    decoded_instr_t instr;
    word_t          pc;
    logic           exc;
  } iq_entry_t;

  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07, OP_ADDIU = 6'h09,
                         OP_SLTI = 6'h0a, OP_SLTIU = 6'h0b, OP_ANDI = 6'h0c, OP_ORI = 6'h0d,
                         OP_XORI = 6'h0e, OP_LUI = 6'h0f, OP_COP0 = 6'h10, OP_LW = 6'h23,
                         OP_SW = 6'h2b;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_JR = 6'h08,
                         F_JALR = 6'h09, F_SYSCALL = 6'h0c, F_BREAK = 6'h0d, F_MFHI = 6'h10,
                         F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13, F_MULT = 6'h18,
                         F_MULTU = 6'h19, F_DIV = 6'h1a, F_DIVU = 6'h1b, F_ADDU = 6'h21,
                         F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26,
                         F_NOR = 6'h27, F_SLT = 6'h2a, F_SLTU = 6'h2b;
  localparam logic [4:0]  CP0_MF = 5'h00, CP0_MT = 5'h04;
  localparam logic [31:0] ERET_WORD = 32'h4200_0018;

  function automatic logic writes_reg(input decoded_instr_t d);
    return d.regwrite && (d.dest != 5'd0);
  endfunction

  function automatic logic uses_mem_unit(input decoded_instr_t d);
    return d.memread || d.memwrite;
  endfunction

  function automatic logic is_serialising(input iq_entry_t e);
    return e.instr.is_eret || e.instr.is_bp || e.instr.is_sys || e.instr.exception_ri || e.exc;
  endfunction
endpackage

// File: rtl/decode_queue_decoder.sv
// Single-instruction MIPS decoder; purely combinational. Unread source fields are left at r0.
module decode_queue_decoder
  import decode_pkg::*;
(
  input  logic [31:0]    instr,
  input  logic [31:0]    pc,
  output decoded_instr_t dec
);
  logic [5:0] op;
  logic [5:0] funct;
  reg_t       rs;
  reg_t       rt;
  reg_t       rd;

  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign funct = instr[5:0];

  always_comb begin
    dec         = '0;
    dec.alu_op  = ALU_NONE;
    dec.imm     = instr[15:0];
    dec.pcplus4 = pc + 32'd4;
    case (op)
      OP_SPECIAL: begin
        case (funct)
          F_SLL, F_SRL, F_SRA: begin
            dec.dest = rd; dec.srca = rt; dec.regwrite = 1'b1;
            dec.alu_op = (funct == F_SLL) ? ALU_SLL : (funct == F_SRL) ? ALU_SRL : ALU_SRA;
          end
          F_JR:      begin dec.is_jump = 1'b1; dec.srca = rs; end
          F_JALR:    begin dec.is_jump = 1'b1; dec.srca = rs; dec.dest = rd; dec.regwrite = 1'b1; end
          F_SYSCALL: dec.is_sys = 1'b1;
          F_BREAK:   dec.is_bp = 1'b1;
          F_MFHI, F_MFLO: begin dec.dest = rd; dec.regwrite = 1'b1; end
          F_MTHI:    begin dec.srca = rs; dec.writes_hi = 1'b1; end
          F_MTLO:    begin dec.srca = rs; dec.writes_lo = 1'b1; end
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin
            dec.srca = rs; dec.srcb = rt; dec.is_multdiv = 1'b1;
            dec.writes_hi = 1'b1; dec.writes_lo = 1'b1;
          end
          F_ADDU, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: begin
            dec.dest = rd; dec.srca = rs; dec.srcb = rt; dec.regwrite = 1'b1;
            case (funct)
              F_ADDU:  dec.alu_op = ALU_ADD;
              F_SUBU:  dec.alu_op = ALU_SUB;
              F_AND:   dec.alu_op = ALU_AND;
              F_OR:    dec.alu_op = ALU_OR;
              F_XOR:   dec.alu_op = ALU_XOR;
              F_NOR:   dec.alu_op = ALU_NOR;
              F_SLT:   dec.alu_op = ALU_SLT;
              default: dec.alu_op = ALU_SLTU;
            endcase
          end
          default: dec.exception_ri = 1'b1;
        endcase
      end
      OP_J:   dec.is_jump = 1'b1;
      OP_JAL: begin dec.is_jump = 1'b1; dec.dest = 5'd31; dec.regwrite = 1'b1; end
      OP_BEQ, OP_BNE: begin dec.is_branch = 1'b1; dec.srca = rs; dec.srcb = rt; end
      OP_BLEZ, OP_BGTZ: begin dec.is_branch = 1'b1; dec.srca = rs; end
      OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
        dec.dest = rt; dec.srca = rs; dec.regwrite = 1'b1;
        case (op)
          OP_ADDIU: dec.alu_op = ALU_ADD;
          OP_SLTI:  dec.alu_op = ALU_SLT;
          OP_SLTIU: dec.alu_op = ALU_SLTU;
          OP_ANDI:  dec.alu_op = ALU_AND;
          OP_ORI:   dec.alu_op = ALU_OR;
          default:  dec.alu_op = ALU_XOR;
        endcase
      end
      OP_LUI: begin dec.dest = rt; dec.regwrite = 1'b1; dec.alu_op = ALU_LUI; end
      OP_LW:  begin dec.dest = rt; dec.srca = rs; dec.regwrite = 1'b1; dec.memread = 1'b1; dec.alu_op = ALU_ADD; end
      OP_SW:  begin dec.srca = rs; dec.srcb = rt; dec.memwrite = 1'b1; dec.alu_op = ALU_ADD; end
      OP_COP0: begin
        if (instr == ERET_WORD)  dec.is_eret = 1'b1;
        else if (rs == CP0_MT)   begin dec.cp0write = 1'b1; dec.srcb = rt; end
        else if (rs == CP0_MF)   begin dec.dest = rt; dec.regwrite = 1'b1; end
        else                     dec.exception_ri = 1'b1;
      end
      default: dec.exception_ri = 1'b1;
    endcase
  end
endmodule

// File: rtl/decode_queue.sv
// Circular decoded-instruction buffer between fetch and in-order issue with dual-issue pairing.
// Entries present one cycle after enqueue; DECODE_QUEUE_BYPASS_EN adds a same-cycle path when empty.
module decode_queue
  import decode_pkg::*;
#(
  parameter int FETCH_WIDTH = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int DEPTH       = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  input  logic [$clog2(FETCH_WIDTH+1)-1:0]     in_count,
  input  logic [FETCH_WIDTH*32-1:0]            in_instr,
  input  logic [FETCH_WIDTH*32-1:0]            in_pc,
  input  logic [FETCH_WIDTH-1:0]               in_exc,
  output logic                                 in_ready,
  input  logic                                 flush,
  output logic [ISSUE_WIDTH-1:0]               out_valid,
  output decoded_instr_t [ISSUE_WIDTH-1:0]     out_instr,
  output logic [ISSUE_WIDTH*32-1:0]            out_pc,
  output logic [ISSUE_WIDTH-1:0]               out_exc,
  input  logic                                 out_ready,
  output logic [$clog2(DEPTH+1)-1:0]           occupancy
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);
  localparam int CW = $clog2(FETCH_WIDTH+1);
  localparam int SW = $clog2(ISSUE_WIDTH+1);

  iq_entry_t        mem [DEPTH];
  logic [DEPTH-1:0] ent_vld;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [OW-1:0]    occ;
  logic             hold_vld;
  logic [SW-1:0]    hold_cnt;

  decoded_instr_t   lane_dec [FETCH_WIDTH];
  iq_entry_t        lane_ent [FETCH_WIDTH];
  logic [PW-1:0]    wr_idx   [FETCH_WIDTH];
  logic [FETCH_WIDTH-1:0] wr_en;
  logic [PW-1:0]    slot_idx [ISSUE_WIDTH];
  iq_entry_t        cand     [ISSUE_WIDTH];
  logic [ISSUE_WIDTH-1:0] cand_vld;
  logic [ISSUE_WIDTH-1:0] sel;

  logic          enq;
  logic          bypass;
  logic          ds_present;
  logic [SW-1:0] out_cnt;
  logic [SW-1:0] deq_n;
  logic [SW-1:0] skip;
  logic [CW-1:0] wr_n;
  logic          ok, cti, unit, hilo, stop, lead_cti, unit_used, hilo_used;

  assign in_ready  = (occ <= OW'(DEPTH - FETCH_WIDTH));
  assign occupancy = occ;
  assign enq       = in_valid && in_ready;

  for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_lane
    decode_queue_decoder u_dec (
      .instr (in_instr[g*32 +: 32]),
      .pc    (in_pc[g*32 +: 32]),
      .dec   (lane_dec[g])
    );
    assign lane_ent[g].instr = lane_dec[g];
    assign lane_ent[g].pc    = in_pc[g*32 +: 32];
    assign lane_ent[g].exc   = in_exc[g];
    assign wr_idx[g] = tail + PW'(g) - PW'(skip);
    assign wr_en[g]  = enq && !flush && (g >= int'(skip)) && (g < int'(in_count));
  end

  for (genvar g = 0; g < ISSUE_WIDTH; g++) begin : g_slot
    assign slot_idx[g]          = head + PW'(g);
    assign out_instr[g]         = cand[g].instr;
    assign out_pc[g*32 +: 32]   = cand[g].pc;
    assign out_exc[g]           = cand[g].exc;
  end

  always_comb begin
    bypass     = 1'b0;
    ds_present = ent_vld[head + PW'(1)];
`ifdef DECODE_QUEUE_BYPASS_EN
    bypass = (occ == '0) && !flush;
    if (bypass) ds_present = enq && (int'(in_count) >= 2);
`endif
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      cand[k]     = mem[slot_idx[k]];
      cand_vld[k] = ent_vld[slot_idx[k]];
`ifdef DECODE_QUEUE_BYPASS_EN
      if (bypass) begin
        cand[k]     = lane_ent[k];
        cand_vld[k] = enq && (k < int'(in_count));
      end
`endif
    end
  end

  // A group grows slot by slot and stops at the first slot that cannot legally join it.
  // While a presented group waits for out_ready, its size is frozen so it cannot grow under the consumer.
  always_comb begin
    sel       = '0;
    ok        = 1'b0;
    cti       = 1'b0;
    unit      = 1'b0;
    hilo      = 1'b0;
    stop      = 1'b0;
    lead_cti  = 1'b0;
    unit_used = 1'b0;
    hilo_used = 1'b0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      ok   = cand_vld[k] && !stop;
      cti  = cand[k].instr.is_branch || cand[k].instr.is_jump;
      unit = uses_mem_unit(cand[k].instr) || cand[k].instr.is_multdiv || cand[k].instr.cp0write;
      hilo = cand[k].instr.writes_hi || cand[k].instr.writes_lo;
      if (k == 0) begin
        if (cti && !ds_present) ok = 1'b0;
      end else begin
        if (is_serialising(cand[k]) || cti || (unit && unit_used) || (hilo && hilo_used)) ok = 1'b0;
        for (int j = 0; j < k; j++) begin
          if (writes_reg(cand[j].instr) &&
              ((cand[j].instr.dest == cand[k].instr.srca) || (cand[j].instr.dest == cand[k].instr.srcb)))
            ok = 1'b0;
        end
      end
      if (hold_vld && (k >= int'(hold_cnt))) ok = 1'b0;
      sel[k] = ok;
      if (!ok || (k == 0 && is_serialising(cand[k])) || (k > 0 && lead_cti)) stop = 1'b1;
      if (k == 0) lead_cti = cti;
      unit_used = unit_used || unit;
      hilo_used = hilo_used || hilo;
    end
  end

  assign out_valid = sel;
  assign out_cnt   = SW'($countones(sel));
  assign deq_n     = (out_ready && !bypass) ? out_cnt : '0;
  assign skip      = (out_ready && bypass) ? out_cnt : '0;
  assign wr_n      = enq ? (in_count - CW'(skip)) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      occ      <= '0;
      ent_vld  <= '0;
      hold_vld <= 1'b0;
      hold_cnt <= '0;
    end else if (flush) begin
      head     <= tail;
      occ      <= '0;
      ent_vld  <= '0;
      hold_vld <= 1'b0;
      hold_cnt <= '0;
    end else begin
      for (int k = 0; k < ISSUE_WIDTH; k++)
        if (k < int'(deq_n)) ent_vld[slot_idx[k]] <= 1'b0;
      for (int i = 0; i < FETCH_WIDTH; i++)
        if (wr_en[i]) ent_vld[wr_idx[i]] <= 1'b1;
      head     <= head + PW'(deq_n);
      tail     <= tail + PW'(wr_n);
      occ      <= occ + OW'(wr_n) - OW'(deq_n);
      hold_vld <= (|sel) && !out_ready;
      hold_cnt <= out_cnt;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++)
      if (wr_en[i] && !reset) mem[wr_idx[i]] <= lane_ent[i];
  end
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue (default build): pairing, branch delay slots, full/wrap, flush, reset.
module tb_decode_queue;
  import decode_pkg::*;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   in_valid;
  logic [1:0]             in_count;
  logic [63:0]            in_instr;
  logic [63:0]            in_pc;
  logic [1:0]             in_exc;
  logic                   in_ready;
  logic                   flush;
  logic [1:0]             out_valid;
  decoded_instr_t [1:0]   out_instr;
  logic [63:0]            out_pc;
  logic [1:0]             out_exc;
  logic                   out_ready;
  logic [3:0]             occupancy;

  int checks   = 0;
  int failures = 0;

  decode_queue #(.FETCH_WIDTH(2), .ISSUE_WIDTH(2), .DEPTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_count  (in_count),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .in_exc    (in_exc),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .out_exc   (out_exc),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_op(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  task automatic drive(input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] p0,
                       input logic [31:0] p1, input int cnt, input logic [1:0] exc);
    in_valid = 1'b1;
    in_count = 2'(cnt);
    in_instr = {i1, i0};
    in_pc    = {p1, p0};
    in_exc   = exc;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_count = 2'd0;
    in_exc   = 2'b00;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [31:0] addu_a, addu_b, addu_c, beq_i, sw_i, addiu_i, addu_raw, sys_i;
  logic [31:0] exp_pc [5];

  initial begin
    addu_a   = r_op(2, 3, 1, 6'h21);
    addu_b   = r_op(5, 6, 4, 6'h21);
    addu_c   = r_op(8, 9, 7, 6'h21);
    beq_i    = i_op(6'h04, 1, 2, 16'd4);
    sw_i     = i_op(6'h2b, 4, 3, 16'd0);
    addiu_i  = i_op(6'h09, 0, 1, 16'd5);
    addu_raw = r_op(1, 1, 2, 6'h21);
    sys_i    = 32'h0000_000c;
    exp_pc   = '{32'h600, 32'h608, 32'h610, 32'h618, 32'h680};

    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    idle();
    @(negedge clk);
    step();
    reset = 1'b0;
    check("reset_occ", 64'(occupancy), 64'd0);
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_ready", 64'(in_ready), 64'd1);

    // in_count=0 is a no-op
    drive(addu_a, addu_b, 32'h80, 32'h84, 0, 2'b00);
    step(); idle();
    check("cnt0_occ", 64'(occupancy), 64'd0);

    // Basic dual issue
    out_ready = 1'b1;
    drive(addu_a, addu_b, 32'h100, 32'h104, 2, 2'b00);
    step(); idle();
    check("dual_valid", 64'(out_valid), 64'b11);
    check("dual_pc0", 64'(out_pc[31:0]), 64'h100);
    check("dual_pc1", 64'(out_pc[63:32]), 64'h104);
    check("dual_dest0", 64'(out_instr[0].dest), 64'd1);
    check("dual_pc4", 64'(out_instr[1].pcplus4), 64'h108);
    step();
    check("dual_drained", 64'(occupancy), 64'd0);
    check("dual_empty_valid", 64'(out_valid), 64'd0);

    // RAW splits the pair
    drive(addiu_i, addu_raw, 32'h200, 32'h204, 2, 2'b00);
    step(); idle();
    check("raw_c1_valid", 64'(out_valid), 64'b01);
    check("raw_c1_pc", 64'(out_pc[31:0]), 64'h200);
    step();
    check("raw_c2_valid", 64'(out_valid), 64'b01);
    check("raw_c2_pc", 64'(out_pc[31:0]), 64'h204);
    step();
    check("raw_drained", 64'(occupancy), 64'd0);

    // Branch waits for its delay slot
    drive(beq_i, 32'h0, 32'h300, 32'h0, 1, 2'b00);
    step(); idle();
    check("br_wait_valid", 64'(out_valid), 64'b00);
    check("br_wait_occ", 64'(occupancy), 64'd1);
    drive(sw_i, 32'h0, 32'h304, 32'h0, 1, 2'b00);
    step(); idle();
    check("br_ds_valid", 64'(out_valid), 64'b11);
    check("br_ds_pc1", 64'(out_pc[63:32]), 64'h304);
    step();
    check("br_drained", 64'(occupancy), 64'd0);

    // Branch at slot 1 ends the group, then leads the next one with its delay slot
    drive(addu_a, beq_i, 32'h400, 32'h404, 2, 2'b00);
    step();
    check("br1_valid", 64'(out_valid), 64'b01);
    check("br1_pc", 64'(out_pc[31:0]), 64'h400);
    drive(addu_c, 32'h0, 32'h408, 32'h0, 1, 2'b00);
    step(); idle();
    check("br1_next_valid", 64'(out_valid), 64'b11);
    check("br1_next_pc0", 64'(out_pc[31:0]), 64'h404);
    step();
    check("br1_drained", 64'(occupancy), 64'd0);

    // Serialising syscall issues alone
    drive(sys_i, addu_a, 32'h500, 32'h504, 2, 2'b00);
    step(); idle();
    check("sys_valid", 64'(out_valid), 64'b01);
    check("sys_pc", 64'(out_pc[31:0]), 64'h500);
    step();
    check("sys_next_valid", 64'(out_valid), 64'b01);
    check("sys_next_pc", 64'(out_pc[31:0]), 64'h504);
    step();

    // Fetch exception is serialising too
    drive(addu_a, addu_b, 32'h540, 32'h544, 2, 2'b01);
    step(); idle();
    check("exc_valid", 64'(out_valid), 64'b01);
    check("exc_flag", 64'(out_exc[0]), 64'd1);
    step();
    check("exc_next_pc", 64'(out_pc[31:0]), 64'h544);
    step();
    check("exc_drained", 64'(occupancy), 64'd0);

    // Fill to full without consuming; the group arriving when full is dropped
    out_ready = 1'b0;
    for (int g = 0; g < 5; g++) begin
      drive(addu_a, addu_b, 32'h600 + 32'(8*g), 32'h604 + 32'(8*g), 2, 2'b00);
      step(); idle();
      check("fill_occ", 64'(occupancy), (g < 4) ? 64'(2*(g+1)) : 64'd8);
      check("fill_ready", 64'(in_ready), (g < 3) ? 64'd1 : 64'd0);
    end
    check("full_head_pc", 64'(out_pc[31:0]), 64'h600);
    check("full_valid", 64'(out_valid), 64'b11);

    // Drain across the index wrap, refilling once mid-drain
    out_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      check("drain_valid", 64'(out_valid), 64'b11);
      check("drain_pc0", 64'(out_pc[31:0]), 64'(exp_pc[n]));
      check("drain_pc1", 64'(out_pc[63:32]), 64'(exp_pc[n] + 32'd4));
      if (n == 1) drive(addu_a, addu_b, 32'h680, 32'h684, 2, 2'b00);
      step(); idle();
    end
    check("drain_occ", 64'(occupancy), 64'd0);

    // Flush with concurrent enqueue and dequeue
    out_ready = 1'b0;
    for (int g = 0; g < 3; g++) begin
      drive(addu_a, addu_b, 32'h6a0 + 32'(8*g), 32'h6a4 + 32'(8*g), 2, 2'b00);
      step(); idle();
    end
    check("pre_flush_occ", 64'(occupancy), 64'd6);
    drive(addu_a, addu_b, 32'h6f0, 32'h6f4, 2, 2'b00);
    flush = 1'b1; out_ready = 1'b1;
    step(); idle();
    flush = 1'b0; out_ready = 1'b0;
    check("flush_occ", 64'(occupancy), 64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_ready", 64'(in_ready), 64'd1);
    drive(addu_a, 32'h0, 32'h700, 32'h0, 1, 2'b00);
    step(); idle();
    check("post_flush_valid", 64'(out_valid), 64'b01);
    check("post_flush_pc", 64'(out_pc[31:0]), 64'h700);
    out_ready = 1'b1;
    step();
    check("post_flush_occ", 64'(occupancy), 64'd0);

    // Reset mid-stream
    out_ready = 1'b0;
    drive(addu_a, addu_b, 32'h800, 32'h804, 2, 2'b00);
    step();
    drive(addu_a, addu_b, 32'h808, 32'h80c, 2, 2'b00);
    step(); idle();
    check("pre_reset_occ", 64'(occupancy), 64'd4);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midreset_occ", 64'(occupancy), 64'd0);
    check("midreset_valid", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
